jtframe_rom_arbiter: RTL and testbench

//  Round-robin arbiter sharing one SDRAM read port (sdram_req/ack, data_read/data_rdy)

---
 rtl/jtframe_rom_arbiter_if.sv | 20 ++
 rtl/jtframe_rom_arbiter.sv | 87 ++++++++
 tb/tb_jtframe_rom_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/jtframe_rom_arbiter_if.sv
// jtframe_rom_arbiter_if: ROM slot and SDRAM read-port bundle for jtframe_rom_arbiter
interface jtframe_rom_arbiter_if #(parameter int N = 4, AW = 22, DW = 32);
  logic [N-1:0]    slot_req;
  logic [N*AW-1:0] slot_addr;
  logic [N-1:0]    slot_ok;
  logic [DW-1:0]   slot_data;
  logic            sdram_req;
  logic [AW-1:0]   sdram_addr;
  logic            sdram_ack;
  logic [DW-1:0]   data_read;
  logic            data_rdy;
  modport master (
    input  slot_req, slot_addr, sdram_ack, data_read, data_rdy,
    output slot_ok, slot_data, sdram_req, sdram_addr
  );
  modport slave (
    output slot_req, slot_addr, sdram_ack, data_read, data_rdy,
    input  slot_ok, slot_data, sdram_req, sdram_addr
  );
endinterface

// File: rtl/jtframe_rom_arbiter.sv
// jtframe_rom_arbiter: round-robin arbiter sharing one SDRAM read port among N ROM slots.
// Optional watchdog enabled by defining JTFRAME_ARB_TIMEOUT_EN.
module jtframe_rom_arbiter #(
  parameter int N    = 4,
  parameter int AW   = 22,
  parameter int DW   = 32,
  parameter int TOUT = 255
) (
  input  logic                 clk_rom,
  input  logic                 rst,
  input  logic                 downloading,
  jtframe_rom_arbiter_if.master bus,
  output logic                 busy,
  output logic                 timeout
);
  localparam int SW = $clog2(N);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;
  state_t        state, state_nx;
  logic [SW-1:0] sel, last, pick, k;
  logic          grant, done, to;
  if (N < 2 || N > 8 || TOUT < 1) begin : g_bad_param
    $error("jtframe_rom_arbiter: unsupported parameters");
  end
  assign grant = !downloading && |bus.slot_req;
  assign done  = bus.data_rdy && (state == WAIT_RDY || (state == WAIT_ACK && bus.sdram_ack));
  // descending scan so the slot closest after last wins
  always_comb begin
    pick = last;
    k    = '0;
    for (int i = N; i >= 1; i--) begin
      k = SW'((int'(last) + i) % N);
      if (bus.slot_req[k]) pick = k;
    end
  end
  always_ff @(posedge clk_rom) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  always_comb begin
    state_nx = state == IDLE     ? (grant ? WAIT_ACK : IDLE) :
               (done || to)      ? IDLE :
               state == WAIT_ACK ? (bus.sdram_ack ? WAIT_RDY : WAIT_ACK) :
               state == WAIT_RDY ? WAIT_RDY : IDLE;
  end
  always_comb begin
    bus.sdram_req = state == WAIT_ACK;
    busy          = state != IDLE;
  end
  always_ff @(posedge clk_rom) begin
    if (rst) begin
      sel            <= '0;
      last           <= SW'(N - 1);
      bus.sdram_addr <= '0;
      bus.slot_data  <= '0;
      bus.slot_ok    <= '0;
    end else begin
      bus.slot_ok <= '0;
      if (state == IDLE && grant) begin
        sel            <= pick;
        bus.sdram_addr <= bus.slot_addr[int'(pick)*AW +: AW];
      end
      if (done) begin
        bus.slot_data <= bus.data_read;
        bus.slot_ok   <= bus.slot_req[sel] ? {{(N-1){1'b0}}, 1'b1} << sel : '0;
      end
      if (done || to) last <= sel;
    end
  end
`ifdef JTFRAME_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TOUT + 1) < 8 ? 8 : $clog2(TOUT + 1);
  logic [CW-1:0] cnt;
  // cnt is zero on the first WAIT_ACK cycle, so the watchdog fires after TOUT waiting cycles
  assign to = state != IDLE && !done && cnt == CW'(TOUT - 1);
  always_ff @(posedge clk_rom) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= state == IDLE ? '0 : cnt + 1'b1;
      timeout <= to;
    end
  end
`else
  assign to      = 1'b0;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_jtframe_rom_arbiter.sv
// tb_jtframe_rom_arbiter: directed checks of grant order, download blocking and completion corner cases
module tb_jtframe_rom_arbiter;
  logic clk_rom = 1'b0, rst = 1'b1, downloading = 1'b0;
  logic busy, timeout, seen;
  int   total = 0, bad = 0;
  jtframe_rom_arbiter_if #(.N(4), .AW(22), .DW(32)) bus ();
  jtframe_rom_arbiter #(.N(4), .AW(22), .DW(32), .TOUT(16)) dut (
    .clk_rom(clk_rom), .rst(rst), .downloading(downloading),
    .bus(bus), .busy(busy), .timeout(timeout)
  );
  always #5 clk_rom = ~clk_rom;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic step();
    @(posedge clk_rom);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_addr(input int i, input logic [21:0] a);
    bus.slot_addr[i*22 +: 22] = a;
  endtask
  task automatic grant_wait(input string tag, input logic [21:0] exp_addr);
    int n = 0;
    while (!bus.sdram_req && n < 50) begin
      step();
      n++;
    end
    check({tag, "_req"}, 64'(bus.sdram_req), 64'(1));
    check({tag, "_addr"}, 64'(bus.sdram_addr), 64'(exp_addr));
  endtask
  task automatic serve(input string tag, input logic [3:0] exp_ok, input logic [21:0] exp_addr,
                       input logic [31:0] d);
    grant_wait(tag, exp_addr);
    bus.sdram_ack = 1'b1;
    step();
    bus.sdram_ack = 1'b0;
    check({tag, "_onehot"}, 64'($countones(bus.slot_ok) <= 1), 64'(1));
    bus.data_read = d;
    bus.data_rdy  = 1'b1;
    step();
    bus.data_rdy = 1'b0;
    check({tag, "_ok"}, 64'(bus.slot_ok), 64'(exp_ok));
    check({tag, "_data"}, 64'(bus.slot_data), 64'(d));
  endtask
  initial begin
    bus.slot_req  = '0;
    bus.slot_addr = '0;
    bus.sdram_ack = 1'b0;
    bus.data_read = '0;
    bus.data_rdy  = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_req", 64'(bus.sdram_req), 64'(0));
    check("rst_addr", 64'(bus.sdram_addr), 64'(0));
    check("rst_ok", 64'(bus.slot_ok), 64'(0));
    check("rst_data", 64'(bus.slot_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_tout", 64'(timeout), 64'(0));
    // single requester, address latched at grant
    set_addr(0, 22'h111); set_addr(1, 22'h222); set_addr(2, 22'h1234); set_addr(3, 22'h333);
    bus.slot_req = 4'b0100;
    step();
    check("t1_req", 64'(bus.sdram_req), 64'(1));
    check("t1_addr", 64'(bus.sdram_addr), 64'(22'h1234));
    set_addr(2, 22'h3FFFF);
    step();
    step();
    check("t1_req_hold", 64'(bus.sdram_req), 64'(1));
    check("t1_addr_latched", 64'(bus.sdram_addr), 64'(22'h1234));
    bus.sdram_ack = 1'b1;
    step();
    bus.sdram_ack = 1'b0;
    check("t1_req_drop", 64'(bus.sdram_req), 64'(0));
    check("t1_busy", 64'(busy), 64'(1));
    step();
    bus.data_read = 32'hCAFEBABE;
    bus.data_rdy  = 1'b1;
    step();
    bus.data_rdy = 1'b0;
    bus.slot_req = 4'b0000;
    check("t1_ok", 64'(bus.slot_ok), 64'(4'b0100));
    check("t1_data", 64'(bus.slot_data), 64'(32'hCAFEBABE));
    check("t1_idle", 64'(busy), 64'(0));
    step();
    check("t1_ok_pulse", 64'(bus.slot_ok), 64'(0));
    // ack/rdy while idle are ignored
    bus.data_read = 32'hDEAD0000;
    bus.data_rdy  = 1'b1;
    bus.sdram_ack = 1'b1;
    step();
    bus.data_rdy  = 1'b0;
    bus.sdram_ack = 1'b0;
    step();
    check("idle_data", 64'(bus.slot_data), 64'(32'hCAFEBABE));
    check("idle_ok", 64'(bus.slot_ok), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
    // all slots requesting from reset: 0,1,2,3,0
    for (int i = 0; i < 4; i++) set_addr(i, 22'(22'h100 + i));
    rst = 1'b1;
    bus.slot_req = 4'b1111;
    step();
    rst = 1'b0;
    serve("t2_s0", 4'b0001, 22'h100, 32'h0000_0A00);
    serve("t2_s1", 4'b0010, 22'h101, 32'h0000_0A01);
    serve("t2_s2", 4'b0100, 22'h102, 32'h0000_0A02);
    serve("t2_s3", 4'b1000, 22'h103, 32'h0000_0A03);
    serve("t2_s0b", 4'b0001, 22'h100, 32'h0000_0A04);
    bus.slot_req = 4'b0000;
    step();
    // download blocks grants for 100 cycles
    downloading  = 1'b1;
    bus.slot_req = 4'b0010;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      seen |= bus.sdram_req | busy | timeout;
    end
    check("t3_blocked", 64'(seen), 64'(0));
    downloading = 1'b0;
    serve("t3_s1", 4'b0010, 22'h101, 32'h3333_0001);
    bus.slot_req = 4'b0000;
    step();
    // download rises during WAIT_RDY of slot3
    bus.slot_req = 4'b1000;
    grant_wait("t4", 22'h103);
    bus.sdram_ack = 1'b1;
    step();
    bus.sdram_ack = 1'b0;
    downloading  = 1'b1;
    bus.slot_req = 4'b1011;
    step();
    bus.data_read = 32'h4444_0003;
    bus.data_rdy  = 1'b1;
    step();
    bus.data_rdy = 1'b0;
    bus.slot_req = 4'b0011;
    check("t4_ok", 64'(bus.slot_ok), 64'(4'b1000));
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      seen |= bus.sdram_req | busy;
    end
    check("t4_blocked", 64'(seen), 64'(0));
    downloading = 1'b0;
    serve("t4_s0", 4'b0001, 22'h100, 32'h4444_0000);
    serve("t4_s1", 4'b0010, 22'h101, 32'h4444_0001);
    bus.slot_req = 4'b0000;
    step();
    // ack and rdy together
    bus.slot_req = 4'b0001;
    grant_wait("t5", 22'h100);
    bus.sdram_ack = 1'b1;
    bus.data_rdy  = 1'b1;
    bus.data_read = 32'h55AA_55AA;
    step();
    bus.sdram_ack = 1'b0;
    bus.data_rdy  = 1'b0;
    bus.slot_req  = 4'b0000;
    check("t5_ok", 64'(bus.slot_ok), 64'(4'b0001));
    check("t5_data", 64'(bus.slot_data), 64'(32'h55AA_55AA));
    check("t5_busy", 64'(busy), 64'(0));
    step();
    check("t5_busy_next", 64'(busy), 64'(0));
    check("t5_ok_pulse", 64'(bus.slot_ok), 64'(0));
    // request dropped mid-transaction: data updates, no slot_ok
    bus.slot_req = 4'b0100;
    grant_wait("t7", 22'h102);
    bus.slot_req  = 4'b0000;
    bus.sdram_ack = 1'b1;
    step();
    bus.sdram_ack = 1'b0;
    bus.data_read = 32'h0000_0077;
    bus.data_rdy  = 1'b1;
    step();
    bus.data_rdy = 1'b0;
    check("t7_ok", 64'(bus.slot_ok), 64'(0));
    check("t7_data", 64'(bus.slot_data), 64'(32'h0000_0077));
    check("t7_busy", 64'(busy), 64'(0));
    // reset mid-transaction
    bus.slot_req = 4'b0001;
    grant_wait("t8", 22'h100);
    rst = 1'b1;
    step();
    check("t8_req", 64'(bus.sdram_req), 64'(0));
    check("t8_busy", 64'(busy), 64'(0));
    check("t8_addr", 64'(bus.sdram_addr), 64'(0));
    check("t8_data", 64'(bus.slot_data), 64'(0));
    bus.slot_req = 4'b0000;
    rst = 1'b0;
    step();
`ifdef JTFRAME_ARB_TIMEOUT_EN
    // watchdog: ack never arrives
    bus.slot_req = 4'b0010;
    grant_wait("t6", 22'h101);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      seen |= !bus.sdram_req | timeout | (|bus.slot_ok);
    end
    check("t6_wait", 64'(seen), 64'(0));
    step();
    check("t6_tout", 64'(timeout), 64'(1));
    check("t6_req", 64'(bus.sdram_req), 64'(0));
    check("t6_ok", 64'(bus.slot_ok), 64'(0));
    step();
    check("t6_tout_pulse", 64'(timeout), 64'(0));
    serve("t6_retry", 4'b0010, 22'h101, 32'h6666_0001);
    bus.slot_req = 4'b0000;
    step();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
